display_sched: RTL and testbench

DISPLAY_SCHED -- requirements
Module: display_sched

---
 rtl/display_sched.sv | 97 +++++++++
 tb/tb_display_sched.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/display_sched.sv
// display_sched: round-robin arbiter that grants one of three requesters the 4-digit display
// for a minimum number of tick pulses, freezing the shown digits if the owner lets go early.
module display_sched #(
  parameter int HOLD_TICKS = 4,
  parameter logic [3:0] BLANK = 4'hF
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        tick,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [2:0]  gnt,
  output logic        frozen
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] FREEZE = 2'd2;
  localparam logic [3:0] LAST = 4'(HOLD_TICKS - 1);
  logic [1:0] state, n_state, owner, n_owner, first, nxt;
  logic [3:0] cnt, n_cnt, cnt_inc;
  logic [15:0] shown, n_shown;
  logic [2:0] others;
  logic owner_req, expire;
  // First active requester strictly after o in cyclic order, wrapping back to o itself.
  function automatic logic [1:0] rr(input logic [2:0] r, input logic [1:0] o);
    rr = o;
    for (int k = 3; k >= 1; k--)
      if (r[(int'(o) + k) % 3]) rr = 2'((int'(o) + k) % 3);
  endfunction
  function automatic logic [15:0] pick(input logic [1:0] o, input logic [15:0] d0, input logic [15:0] d1,
                                       input logic [15:0] d2);
    pick = o == 2'd0 ? d0 : o == 2'd1 ? d1 : d2;
  endfunction
  assign shown = {digit3, digit2, digit1, digit0};
  assign owner_req = req[owner];
  assign others = req & ~(3'b001 << owner);
  assign expire = tick && cnt == LAST;
  assign first = rr(req, owner);
  assign nxt = rr(others, owner);
  assign cnt_inc = (tick && cnt < LAST) ? cnt + 4'd1 : cnt;
  always_comb begin
    n_state = state;
    n_owner = owner;
    n_cnt = cnt_inc;
    n_shown = shown;
    if (state == IDLE) begin
      n_cnt = '0;
      n_shown = {4{BLANK}};
      if (|req) begin
        n_state = SHOW;
        n_owner = first;
        n_shown = pick(first, data0, data1, data2);
      end
    end else if (expire) begin
      if (|others) begin
        n_state = SHOW;
        n_owner = nxt;
        n_cnt = '0;
        n_shown = pick(nxt, data0, data1, data2);
      end else if (state == SHOW && owner_req) begin
        n_shown = pick(owner, data0, data1, data2);
      end else begin
        n_state = IDLE;
        n_cnt = '0;
        n_shown = {4{BLANK}};
      end
    end else if (owner_req) begin
      n_state = SHOW;
      n_shown = pick(owner, data0, data1, data2);
    end else begin
      n_state = FREEZE;
    end
  end
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state <= IDLE;
      owner <= 2'd2;
      cnt <= '0;
      gnt <= '0;
      frozen <= 1'b0;
      {digit3, digit2, digit1, digit0} <= {4{BLANK}};
    end else begin
      state <= n_state;
      owner <= n_owner;
      cnt <= n_cnt;
      gnt <= n_state == IDLE ? 3'b000 : 3'b001 << n_owner;
      frozen <= n_state == FREEZE;
      {digit3, digit2, digit1, digit0} <= n_shown;
    end
  end
endmodule

// File: tb/tb_display_sched.sv
// tb_display_sched: directed and random stimulus checked against a behavioural model of the
// display arbitration rules.
module tb_display_sched;
  localparam int H = 4;
  logic clk = 0, rst_p = 1, tick = 0;
  logic [2:0] req = '0;
  logic [15:0] data0 = '0, data1 = '0, data2 = '0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [2:0] gnt;
  logic frozen;
  int errors = 0, checks = 0;
  int m_mode = 0, m_own = 2, m_held = 0;
  logic [15:0] m_dig = 16'hFFFF;

  display_sched #(.HOLD_TICKS(H), .BLANK(4'hF)) dut (
    .clk(clk), .rst_p(rst_p), .tick(tick), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .gnt(gnt), .frozen(frozen));

  always #5 clk = ~clk;

  function automatic logic [15:0] dat(input int o);
    return o == 0 ? data0 : o == 1 ? data1 : data2;
  endfunction

  function automatic int next_after(input int o, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) if (r[(o + k) % 3]) return (o + k) % 3;
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_own = 2; m_held = 0; m_dig = 16'hFFFF;
  endtask

  // Modes: 0 nobody owns, 1 owner shown live, 2 owner's last frame frozen.
  task automatic model_step();
    logic [2:0] oth;
    bit done;
    if (m_mode == 0) begin
      if (req != 0) begin
        m_own = next_after(m_own, req); m_mode = 1; m_held = 0; m_dig = dat(m_own);
      end
    end else begin
      done = tick && m_held == H - 1;
      if (tick && m_held < H - 1) m_held++;
      oth = req;
      oth[m_own] = 1'b0;
      if (done) begin
        if (oth != 0) begin
          m_own = next_after(m_own, oth); m_mode = 1; m_held = 0; m_dig = dat(m_own);
        end else if (m_mode == 1 && req[m_own]) m_dig = dat(m_own);
        else begin
          m_mode = 0; m_held = 0; m_dig = 16'hFFFF;
        end
      end else if (req[m_own]) begin
        m_mode = 1; m_dig = dat(m_own);
      end else m_mode = 2;
    end
  endtask

  task automatic check(input string tag);
    logic [2:0] eg;
    eg = m_mode == 0 ? 3'b000 : 3'(1 << m_own);
    checks++;
    assert (gnt === eg) else begin
      errors++; $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
    end
    checks++;
    assert ({digit3, digit2, digit1, digit0} === m_dig) else begin
      errors++; $error("FAIL %s digits got=%h exp=%h", tag, {digit3, digit2, digit1, digit0}, m_dig);
    end
    checks++;
    assert (frozen === (m_mode == 2)) else begin
      errors++; $error("FAIL %s frozen got=%b exp=%b", tag, frozen, m_mode == 2);
    end
  endtask

  task automatic cyc(input logic t, input logic [2:0] r, input string tag);
    tick = t; req = r;
    @(posedge clk);
    model_step();
    #1 check(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_p = 1;
    model_reset();
    #1 check(tag);
    @(posedge clk); #1 check(tag);
    rst_p = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset");
    rst_p = 0;
    // Single owner keeps the display while requesting.
    data0 = 16'h1234;
    cyc(0, 3'b001, "grant0");
    for (int i = 0; i < 10; i++) cyc(i % 2 == 0, 3'b001, "keep0");
    do_reset("rst1");
    // Round-robin alternation between requesters 0 and 1.
    data1 = 16'hABCD;
    cyc(0, 3'b011, "rr_start");
    for (int i = 0; i < 20; i++) cyc(i % 2 == 1, 3'b011, "rr_alt");
    do_reset("rst2");
    // Early drop freezes the last frame.
    data0 = 16'h5678;
    cyc(0, 3'b001, "fz_grant");
    cyc(1, 3'b001, "fz_tick1");
    cyc(0, 3'b000, "fz_enter");
    data0 = 16'h9999;
    cyc(0, 3'b000, "fz_hold");
    cyc(1, 3'b000, "fz_tick2");
    cyc(1, 3'b000, "fz_tick3");
    cyc(0, 3'b000, "fz_wait");
    cyc(1, 3'b000, "fz_expire");
    cyc(0, 3'b000, "fz_idle");
    // Saturated owner 2 yields only on the next tick.
    data2 = 16'h2222; data0 = 16'h0000;
    cyc(0, 3'b100, "sat_grant");
    for (int i = 0; i < 10; i++) cyc(1, 3'b100, "sat_tick");
    cyc(0, 3'b101, "sat_newreq");
    cyc(0, 3'b101, "sat_wait");
    cyc(1, 3'b101, "sat_switch");
    // Reset during freeze, then requester 1 wins.
    cyc(0, 3'b100, "pre_fz");
    cyc(0, 3'b010, "fz2");
    do_reset("rst_fz");
    cyc(0, 3'b010, "post_rst");
    do_reset("rst3");
    // Drop exactly on the expiry tick goes straight to idle.
    cyc(0, 3'b001, "ex_grant");
    for (int i = 0; i < 3; i++) cyc(1, 3'b001, "ex_tick");
    cyc(1, 3'b000, "ex_drop");
    cyc(0, 3'b000, "ex_idle");
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data2 = 16'($urandom);
      if ($urandom_range(0, 150) == 0) do_reset("rnd_rst");
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0 ? 3'($urandom) : req, "random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
